// File: rtl/sev_seg_scan.sv
// sev_seg_scan: multiplexed seven-segment scan controller with double-buffered frames
module sev_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       data_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [3:0]                    digit,
    output logic                          dp_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         sh_data_q, sh_data_d, pd_data_q, pd_data_d;
    logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d, pd_blank_q, pd_blank_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, pd_dp_q, pd_dp_d;
    logic                  pend_q, pend_d;
    logic                  fs_q, fs_d;
    logic                  tick, boundary, lit;

    // Prescaler, digit stepping and frame buffer swap at the frame boundary
    always_comb begin
        tick       = cnt_q == CW'(REFRESH_DIV - 1);
        boundary   = tick && idx_q == IW'(NUM_DIGITS - 1);
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        idx_d      = boundary ? '0 : tick ? idx_q + IW'(1) : idx_q;
        fs_d       = boundary;
        pd_data_d  = (load && !boundary) ? data_in  : pd_data_q;
        pd_blank_d = (load && !boundary) ? blank_in : pd_blank_q;
        pd_dp_d    = (load && !boundary) ? dp_in    : pd_dp_q;
        pend_d     = boundary ? 1'b0 : (load || pend_q);
        sh_data_d  = !boundary ? sh_data_q  : load ? data_in  : pend_q ? pd_data_q  : sh_data_q;
        sh_blank_d = !boundary ? sh_blank_q : load ? blank_in : pend_q ? pd_blank_q : sh_blank_q;
        sh_dp_d    = !boundary ? sh_dp_q    : load ? dp_in    : pend_q ? pd_dp_q    : sh_dp_q;
    end

    // State registers; reset blanks the display and drops any pending frame
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            fs_q       <= 1'b0;
            pend_q     <= 1'b0;
            pd_data_q  <= '0;
            pd_blank_q <= '1;
            pd_dp_q    <= '0;
            sh_data_q  <= '0;
            sh_blank_q <= '1;
            sh_dp_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            fs_q       <= fs_d;
            pend_q     <= pend_d;
            pd_data_q  <= pd_data_d;
            pd_blank_q <= pd_blank_d;
            pd_dp_q    <= pd_dp_d;
            sh_data_q  <= sh_data_d;
            sh_blank_q <= sh_blank_d;
            sh_dp_q    <= sh_dp_d;
        end
    end

    // Output decode: one anode low after the guard window unless blanked or disabled
    always_comb begin
        lit         = enable && cnt_q >= CW'(GUARD) && !sh_blank_q[idx_q];
        an          = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        digit       = sh_data_q[{idx_q, 2'b00} +: 4];
        dp_n        = !(lit && sh_dp_q[idx_q]);
        digit_idx   = idx_q;
        frame_start = fs_q;
    end
endmodule

// File: tb/tb_sev_seg_scan.sv
// tb_sev_seg_scan: table-driven and scoreboard-checked bench for sev_seg_scan
module tb_sev_seg_scan;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int G  = 1;
    localparam int FR = ND * RD;

    logic        clk = 1'b0;
    logic        reset, enable, load;
    logic [15:0] data_in;
    logic [3:0]  blank_in, dp_in;
    logic [3:0]  an, digit;
    logic        dp_n, frame_start;
    logic [1:0]  digit_idx;

    sev_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(G)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .data_in(data_in), .blank_in(blank_in), .dp_in(dp_in),
        .an(an), .digit(digit), .dp_n(dp_n),
        .digit_idx(digit_idx), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] dg;
        logic       dpn;
        logic [1:0] idx;
        logic       fs;
    } out_t;

    typedef struct {
        logic        ld;
        logic [15:0] d;
        logic [3:0]  b;
        logic [3:0]  p;
        out_t        e;
    } vec_t;

    out_t sb[$];
    vec_t tbl[32];
    int   checks = 0;
    int   errors = 0;

    // reference model: cycles since reset plus displayed/pending frames
    int          mt;
    logic [15:0] m_data, p_data;
    logic [3:0]  m_blank, m_dp, p_blank, p_dp;
    logic        p_flag, m_fs;

    task automatic model_edge(input logic r, input logic ld, input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
        if (r) begin
            mt = 0; m_data = '0; m_blank = '1; m_dp = '0; p_flag = 0; m_fs = 0;
        end else begin
            m_fs = (mt % FR) == FR - 1;
            if (m_fs) begin
                if (ld) begin m_data = d; m_blank = b; m_dp = p; end
                else if (p_flag) begin m_data = p_data; m_blank = p_blank; m_dp = p_dp; end
                p_flag = 0;
            end else if (ld) begin
                p_data = d; p_blank = b; p_dp = p; p_flag = 1;
            end
            mt++;
        end
    endtask

    function automatic out_t model_out(input logic en);
        out_t o;
        int   s, c;
        logic lit;
        c = mt % RD;
        s = (mt / RD) % ND;
        lit = en && c >= G && !m_blank[s];
        o.an  = lit ? ~(4'b0001 << s) : 4'b1111;
        o.dg  = m_data[s*4 +: 4];
        o.dpn = lit ? ~m_dp[s] : 1'b1;
        o.idx = 2'(s);
        o.fs  = m_fs;
        return o;
    endfunction

    task automatic step(input logic r, input logic ld, input logic [15:0] d, input logic [3:0] b, input logic [3:0] p,
                        input logic en, input logic use_tbl, input out_t te, input string nm);
        out_t got, e;
        reset = r; load = ld; data_in = d; blank_in = b; dp_in = p; enable = en;
        model_edge(r, ld, d, b, p);
        sb.push_back(use_tbl ? te : model_out(en));
        @(posedge clk);
        #1;
        got = '{an, digit, dp_n, digit_idx, frame_start};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s t=%0d: got an=%b digit=%h dp_n=%b idx=%0d fs=%b, expected an=%b digit=%h dp_n=%b idx=%0d fs=%b",
                     nm, mt, got.an, got.dg, got.dpn, got.idx, got.fs, e.an, e.dg, e.dpn, e.idx, e.fs);
        end
    endtask

    task automatic idle(input int n, input logic en, input string nm);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 4'h0, 4'h0, en, 0, '0, nm);
    endtask

    task automatic seek(input int ph, input string nm);
        for (int i = 0; i < FR && (mt % FR) != ph; i++) idle(1, 1, nm);
    endtask

    task automatic ld(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p, input string nm);
        step(0, 1, d, b, p, 1, 0, '0, nm);
    endtask

    function automatic out_t mk(input logic [3:0] a, input logic [3:0] dg, input logic dpn, input logic [1:0] idx, input logic fs);
        return '{a, dg, dpn, idx, fs};
    endfunction

    initial begin
        // first frame after reset: load 4321 at t=0, blank until boundary, then one displayed frame
        tbl[0] = '{1, 16'h4321, 4'b0000, 4'b0100, mk(4'hF, 4'h0, 1, 0, 0)};
        for (int i = 1; i < 15; i++) tbl[i] = '{0, 16'h0, 4'h0, 4'h0, mk(4'hF, 4'h0, 1, 2'((i + 1) / 4), 0)};
        tbl[15] = '{0, 16'h0, 4'h0, 4'h0, mk(4'hF, 4'h1, 1, 0, 1)};
        for (int i = 16; i < 19; i++) tbl[i] = '{0, 16'h0, 4'h0, 4'h0, mk(4'b1110, 4'h1, 1, 0, 0)};
        tbl[19] = '{0, 16'h0, 4'h0, 4'h0, mk(4'hF, 4'h2, 1, 1, 0)};
        for (int i = 20; i < 23; i++) tbl[i] = '{0, 16'h0, 4'h0, 4'h0, mk(4'b1101, 4'h2, 1, 1, 0)};
        tbl[23] = '{0, 16'h0, 4'h0, 4'h0, mk(4'hF, 4'h3, 1, 2, 0)};
        for (int i = 24; i < 27; i++) tbl[i] = '{0, 16'h0, 4'h0, 4'h0, mk(4'b1011, 4'h3, 0, 2, 0)};
        tbl[27] = '{0, 16'h0, 4'h0, 4'h0, mk(4'hF, 4'h4, 1, 3, 0)};
        for (int i = 28; i < 31; i++) tbl[i] = '{0, 16'h0, 4'h0, 4'h0, mk(4'b0111, 4'h4, 1, 3, 0)};
        tbl[31] = '{0, 16'h0, 4'h0, 4'h0, mk(4'hF, 4'h1, 1, 0, 1)};

        for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 4'h0, 4'h0, 1, 1, mk(4'hF, 4'h0, 1, 0, 0), "reset");
        for (int i = 0; i < 32; i++) step(0, tbl[i].ld, tbl[i].d, tbl[i].b, tbl[i].p, 1, 1, tbl[i].e, $sformatf("tbl%0d", i));

        // two loads in one frame: last wins
        ld(16'hAAAA, 4'h0, 4'h1, "load_a");
        idle(5, 1, "between");
        ld(16'h5555, 4'h0, 4'h2, "load_5");
        seek(FR - 1, "seek_b1");
        idle(FR + 1, 1, "frame_5555");

        // boundary-cycle load overrides an older pending frame and clears the flag
        seek(3, "seek_p");
        ld(16'h1111, 4'h0, 4'h0, "load_1");
        seek(FR - 1, "seek_b2");
        ld(16'h9999, 4'h0, 4'h8, "load_bnd");
        idle(2 * FR, 1, "frame_9999");

        // blanked digits and enable toggling mid-slot
        seek(2, "seek_p3");
        ld(16'h8765, 4'b1010, 4'b1111, "load_blank");
        seek(FR - 1, "seek_b3");
        idle(6, 1, "blank_on");
        idle(3, 0, "enable_off");
        idle(2 * FR, 1, "blank_run");

        // reset with a pending load: pending frame must never appear
        seek(5, "seek_p4");
        ld(16'h1234, 4'h0, 4'hF, "load_pend");
        idle(2, 1, "pend_wait");
        step(1, 0, 16'h0, 4'h0, 4'h0, 1, 1, mk(4'hF, 4'h0, 1, 0, 0), "mid_reset");
        idle(2 * FR + 4, 1, "after_reset");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
